// File: rtl/sum_accumulator.sv
// sum_accumulator: sums N_SAMPLES 9-bit adder results ({in_cout, in_sum}) per frame
// and presents the total with a valid/ready handshake. The overflow flag is sticky
// for the rest of the frame.
// Optional build macro: SUM_ACCUMULATOR_SAT_EN -- when defined, the result saturates at
// 2^ACC_W-1 once the frame overflows; otherwise the result wraps modulo 2^ACC_W.
module sum_accumulator #(
    parameter int unsigned N_SAMPLES = 8,
    parameter int unsigned ACC_W     = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [7:0]       in_sum,
    input  logic             in_cout,
    output logic             in_ready,
    input  logic             clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] result,
    output logic             overflow,
    output logic [3:0]       count
);

    typedef enum logic [1:0] {StIdle, StAcc, StHold} state_e;

    // Count value whose accept completes the frame
    localparam logic [3:0] LastCount = 4'(N_SAMPLES - 1);

    state_e           state_q, state_d;
    logic [ACC_W-1:0] result_q, result_d;
    logic [3:0]       count_q, count_d;
    logic             overflow_q, overflow_d;

    logic [ACC_W:0]   sample;
    logic [ACC_W:0]   base;
    logic [ACC_W:0]   sum;
    logic             sum_ovf;
    logic             accept;

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            result_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            result_q   <= result_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Next-state logic; clear outranks both accept and the result handshake
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle:  if (accept) state_d = StAcc;
                StAcc:   if (accept && (count_q == LastCount)) state_d = StHold;
                StHold:  if (out_ready) state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    // Handshake outputs; in_ready depends only on state and clear, never on out_ready
    always_comb begin
        in_ready  = (state_q != StHold) && !clear;
        out_valid = (state_q == StHold);
    end

    // Accumulate on accept; a new frame starts from zero rather than the stale total
    always_comb begin
        sample     = {{(ACC_W - 8){1'b0}}, in_cout, in_sum};
        base       = (state_q == StAcc) ? {1'b0, result_q} : '0;
        sum        = base + sample;
        sum_ovf    = sum[ACC_W];
        accept     = in_valid && in_ready;
        result_d   = result_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (clear) begin
            result_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else if (accept) begin
            count_d    = (state_q == StAcc) ? count_q + 4'd1 : 4'd1;
            overflow_d = overflow_q || sum_ovf;
`ifdef SUM_ACCUMULATOR_SAT_EN
            result_d   = (overflow_q || sum_ovf) ? '1 : sum[ACC_W-1:0];
`else
            result_d   = sum[ACC_W-1:0];
`endif
        end else if ((state_q == StHold) && out_ready) begin
            result_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end
    end

    assign result   = result_q;
    assign count    = count_q;
    assign overflow = overflow_q;

endmodule
